// File: rtl/spwtcr_pkg.sv
// Shared constants and types for the SpaceWire receive character decoder.
// Control codes, NULL hunt pattern, FIFO word encodings and FSM states.
package spwtcr_pkg;

    localparam logic [1:0] CTRL_FCT = 2'd0;
    localparam logic [1:0] CTRL_EOP = 2'd1;
    localparam logic [1:0] CTRL_EEP = 2'd2;
    localparam logic [1:0] CTRL_ESC = 2'd3;

    // Last 7 bits of ESC+FCT in arrival order (oldest first);
    // the ESC parity bit is don't-care and is not kept.
    localparam logic [6:0] NULL_PAT = 7'b1110100;

    localparam logic [8:0] WORD_EOP = 9'h100;
    localparam logic [8:0] WORD_EEP = 9'h101;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_HEADER,
        ST_PAYLOAD
    } rx_state_e;

endpackage

// File: rtl/spwtcr_rx_credit_counter.sv
// Outstanding receive credit: +8 per FCT sent, -1 per accepted N-char.
// An N-char arriving with zero credit is refused and flags credit_error.
module spwtcr_rx_credit_counter #(
    parameter int CREDIT_MAX = 56
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic       rx_enable,
    input  logic       fct_sent,
    input  logic       nchar,
    output logic       accept,
    output logic [5:0] credit_o,
    output logic       credit_error
);

    logic [5:0] credit_q, credit_d;
    logic       err_q;
    logic [6:0] sum;

    // Accept only when credit is available; add 8 per FCT and saturate.
    always_comb begin
        accept   = nchar && (credit_q != 6'd0);
        sum      = {1'b0, credit_q}
                 + (fct_sent ? 7'd8 : 7'd0)
                 - {6'd0, accept};
        credit_d = (sum > 7'(CREDIT_MAX)) ? 6'(CREDIT_MAX) : sum[5:0];
    end

    // Credit register and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (RESET || !rx_enable) begin
            credit_q <= 6'd0;
            err_q    <= 1'b0;
        end else begin
            credit_q <= credit_d;
            if (nchar && !accept)
                err_q <= 1'b1;
        end
    end

    assign credit_o     = credit_q;
    assign credit_error = err_q;

endmodule

// File: rtl/spwtcr_rx_char_decoder.sv
// Receive character decoder: NULL hunt, character assembly, parity check,
// escape decode, FIFO writes and credit tracking.
module spwtcr_rx_char_decoder
    import spwtcr_pkg::*;
#(
    parameter int CREDIT_MAX = 56
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic       rx_enable,
    input  logic       rx_bit,
    input  logic       rx_bit_valid,
    input  logic       fct_sent,
    output logic       we,
    output logic [8:0] data_o,
    output logic       got_null,
    output logic       got_fct,
    output logic       got_timecode,
    output logic [7:0] timecode_o,
    output logic       got_first_null,
    output logic       parity_error,
    output logic       escape_error,
    output logic       credit_error,
    output logic [5:0] credit_o
);

    rx_state_e  state_q;
    logic [6:0] sr_q;
    logic [6:0] dat_q;
    logic [2:0] cnt_q;
    logic       p_q, flag_q, par_q, pacc_q, esc_q;
    logic       we_q, null_q, fct_q, tc_q, first_q, perr_q, eerr_q;
    logic [8:0] data_q;
    logic [7:0] tcv_q;

    logic [6:0] sr_d;
    logic       last_bit, par_ok, nchar, accept;
    logic [1:0] code;
    logic [7:0] byte_d;

    // Decode of the character completing on this bit.
    always_comb begin
        sr_d     = {sr_q[5:0], rx_bit};
        code     = {rx_bit, dat_q[6]};
        byte_d   = {rx_bit, dat_q};
        par_ok   = p_q ^ flag_q ^ par_q;
        last_bit = rx_bit_valid && (state_q == ST_PAYLOAD)
                && (cnt_q == (flag_q ? 3'd1 : 3'd7));
        nchar    = last_bit && par_ok && !esc_q
                && (!flag_q || code == CTRL_EOP || code == CTRL_EEP);
    end

    spwtcr_rx_credit_counter #(
        .CREDIT_MAX(CREDIT_MAX)
    ) u_credit (
        .clk         (clk),
        .RESET       (RESET),
        .rx_enable   (rx_enable),
        .fct_sent    (fct_sent),
        .nchar       (nchar),
        .accept      (accept),
        .credit_o    (credit_o),
        .credit_error(credit_error)
    );

    // Character FSM with registered outputs and one-cycle pulses.
    always_ff @(posedge clk) begin
        if (RESET || !rx_enable) begin
            state_q <= ST_HUNT;
            sr_q    <= 7'd0;
            dat_q   <= 7'd0;
            cnt_q   <= 3'd0;
            p_q     <= 1'b0;
            flag_q  <= 1'b0;
            par_q   <= 1'b0;
            pacc_q  <= 1'b0;
            esc_q   <= 1'b0;
            we_q    <= 1'b0;
            null_q  <= 1'b0;
            fct_q   <= 1'b0;
            tc_q    <= 1'b0;
            first_q <= 1'b0;
            perr_q  <= 1'b0;
            eerr_q  <= 1'b0;
            data_q  <= 9'd0;
            tcv_q   <= 8'd0;
        end else begin
            we_q   <= 1'b0;
            null_q <= 1'b0;
            fct_q  <= 1'b0;
            tc_q   <= 1'b0;
            if (rx_bit_valid) begin
                unique case (state_q)
                    ST_HUNT: begin
                        sr_q <= sr_d;
                        if (sr_d == NULL_PAT) begin
                            first_q <= 1'b1;
                            null_q  <= 1'b1;
                            state_q <= ST_HEADER;
                            cnt_q   <= 3'd0;
                            par_q   <= 1'b0;
                            pacc_q  <= 1'b0;
                            esc_q   <= 1'b0;
                        end
                    end
                    ST_HEADER: begin
                        if (cnt_q == 3'd0) begin
                            p_q   <= rx_bit;
                            cnt_q <= 3'd1;
                        end else begin
                            flag_q  <= rx_bit;
                            cnt_q   <= 3'd0;
                            state_q <= ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        dat_q  <= {rx_bit, dat_q[6:1]};
                        cnt_q  <= cnt_q + 3'd1;
                        pacc_q <= pacc_q ^ rx_bit;
                        if (last_bit) begin
                            state_q <= ST_HEADER;
                            cnt_q   <= 3'd0;
                            par_q   <= pacc_q ^ rx_bit;
                            pacc_q  <= 1'b0;
                            esc_q   <= 1'b0;
                            if (!par_ok) begin
                                perr_q <= 1'b1;
                            end else if (flag_q) begin
                                unique case (code)
                                    CTRL_ESC: begin
                                        if (esc_q) eerr_q <= 1'b1;
                                        else       esc_q  <= 1'b1;
                                    end
                                    CTRL_FCT: begin
                                        if (esc_q) null_q <= 1'b1;
                                        else       fct_q  <= 1'b1;
                                    end
                                    CTRL_EOP, CTRL_EEP: begin
                                        if (esc_q) begin
                                            eerr_q <= 1'b1;
                                        end else if (accept) begin
                                            we_q   <= 1'b1;
                                            data_q <= (code == CTRL_EOP)
                                                    ? WORD_EOP : WORD_EEP;
                                        end
                                    end
                                endcase
                            end else if (esc_q) begin
                                tc_q  <= 1'b1;
                                tcv_q <= byte_d;
                            end else if (accept) begin
                                we_q   <= 1'b1;
                                data_q <= {1'b0, byte_d};
                            end
                        end
                    end
                    default: state_q <= ST_HUNT;
                endcase
            end
        end
    end

    assign we             = we_q;
    assign data_o         = data_q;
    assign got_null       = null_q;
    assign got_fct        = fct_q;
    assign got_timecode   = tc_q;
    assign timecode_o     = tcv_q;
    assign got_first_null = first_q;
    assign parity_error   = perr_q;
    assign escape_error   = eerr_q;

endmodule
